// File: rtl/uart_tx_fifo_if.sv
// Byte-push and status bundle for the FIFO-buffered UART transmitter.
interface uart_tx_fifo_if #(
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic          transmit;
   logic [7:0]    tx_byte;
   logic          tx;
   logic          is_transmitting;
   logic          fifo_full;
   logic [CW-1:0] fifo_count;
   logic          overflow;

   modport master (
      output transmit, tx_byte,
      input  tx, is_transmitting, fifo_full, fifo_count, overflow
   );

   modport slave (
      input  transmit, tx_byte,
      output tx, is_transmitting, fifo_full, fifo_count, overflow
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a DEPTH-entry byte FIFO; next frame starts
// straight out of STOP when more bytes are queued.
module uart_tx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 5208,
   parameter int unsigned DEPTH        = 8
) (
   input  logic            clk,
   input  logic            rst,
   uart_tx_fifo_if.slave   bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned BW = 16;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    mem_q [DEPTH];

   logic          pop;
   logic          push;
   logic          full;
   logic          bit_end;
   logic [2:0]    bit_nxt;

   assign full    = (count_q == CW'(DEPTH));
   assign bit_end = (baud_q == BW'(CLKS_PER_BIT - 1));
   assign bit_nxt = bit_q + 3'd1;

   // Frame sequencer; pop happens on IDLE->START and STOP->START.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = START;
               baud_d  = '0;
               bit_d   = '0;
               shift_d = mem_q[rd_ptr_q];
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_nxt;
                  tx_d  = shift_q[bit_nxt];
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_d = '0;
               if (count_q != '0) begin
                  pop     = 1'b1;
                  state_d = START;
                  bit_d   = '0;
                  shift_d = mem_q[rd_ptr_q];
                  tx_d    = 1'b0;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = '0;
            bit_d   = '0;
            tx_d    = 1'b1;
         end
      endcase
   end

   // A push into a full FIFO is still taken when the head leaves on the same edge.
   always_comb begin
      push       = bus.transmit && (!full || pop);
      count_d    = count_q + CW'(push) - CW'(pop);
      wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      overflow_d = overflow_q || (bus.transmit && !push);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is not reset; only entries below count_q are ever read.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.tx_byte;
   end

   assign bus.tx              = tx_q;
   assign bus.is_transmitting = (state_q != IDLE) || (count_q != '0);
   assign bus.fifo_full       = full;
   assign bus.fifo_count      = count_q;
   assign bus.overflow        = overflow_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CLKS_PER_BIT=4, DEPTH=4.
module tb_uart_tx_fifo;
   localparam int unsigned CPB   = 4;
   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors     = 0;
   int   miscompares = 0;

   uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Line level for bit slot i of a frame: start, 8 data LSB first, stop.
   function automatic logic line_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i == 9) return 1'b1;
      return b[i-1];
   endfunction

   // Checks frame cycles skip..39, optionally pushing a byte on the last edge.
   task automatic frame(input logic [7:0] b, input int skip,
                        input logic push_en, input logic [7:0] push_b);
      for (int k = skip; k < 40; k++) begin
         chk($sformatf("frame_%02h_c%0d", b, k), 32'(bus.tx), 32'(line_bit(b, k / 4)));
         if (k == 39 && push_en) begin
            bus.transmit = 1'b1;
            bus.tx_byte  = push_b;
         end
         @(negedge clk);
      end
      bus.transmit = 1'b0;
   endtask

   task automatic push_seq(input logic [7:0] b []);
      foreach (b[i]) begin
         bus.transmit = 1'b1;
         bus.tx_byte  = b[i];
         @(negedge clk);
      end
      bus.transmit = 1'b0;
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_tx"},    32'(bus.tx), 32'd1);
      chk({tag, "_busy"},  32'(bus.is_transmitting), 32'd0);
      chk({tag, "_count"}, 32'(bus.fifo_count), 32'd0);
   endtask

   initial begin
      bus.transmit = 1'b0;
      bus.tx_byte  = 8'h00;

      // Reset hold values
      repeat (2) @(negedge clk);
      idle_chk("rst");
      chk("rst_full", 32'(bus.fifo_full), 32'd0);
      chk("rst_ovf",  32'(bus.overflow),  32'd0);
      rst = 1'b0;

      // Quiet line after reset
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk($sformatf("idle_tx_%0d", i),   32'(bus.tx), 32'd1);
         chk($sformatf("idle_busy_%0d", i), 32'(bus.is_transmitting), 32'd0);
      end

      // Single byte 0xA5: tx still high one edge after the push
      push_seq('{8'hA5});
      chk("single_lat_tx",  32'(bus.tx), 32'd1);
      chk("single_count",   32'(bus.fifo_count), 32'd1);
      chk("single_busy",    32'(bus.is_transmitting), 32'd1);
      @(negedge clk);
      frame(8'hA5, 0, 1'b0, 8'h00);
      idle_chk("single_end");

      // Back-to-back 0x00, 0xFF
      bus.transmit = 1'b1;
      bus.tx_byte  = 8'h00;
      @(negedge clk);
      bus.tx_byte  = 8'hFF;
      @(negedge clk);
      bus.transmit = 1'b0;
      chk("b2b_count", 32'(bus.fifo_count), 32'd1);
      frame(8'h00, 0, 1'b0, 8'h00);
      frame(8'hFF, 0, 1'b0, 8'h00);
      idle_chk("b2b_end");

      // Full FIFO, push accepted alongside the STOP->START pop
      push_seq('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
      chk("full_flag",  32'(bus.fifo_full),  32'd1);
      chk("full_count", 32'(bus.fifo_count), 32'd4);
      chk("full_ovf",   32'(bus.overflow),   32'd0);
      frame(8'h11, 3, 1'b1, 8'h77);
      chk("fullpop_count", 32'(bus.fifo_count), 32'd4);
      chk("fullpop_ovf",   32'(bus.overflow),   32'd0);
      chk("fullpop_flag",  32'(bus.fifo_full),  32'd1);
      frame(8'h22, 0, 1'b0, 8'h00);
      frame(8'h33, 0, 1'b0, 8'h00);
      frame(8'h44, 0, 1'b0, 8'h00);
      frame(8'h55, 0, 1'b0, 8'h00);
      frame(8'h77, 0, 1'b0, 8'h00);
      idle_chk("fullpop_end");

      // Six pushes: one shifting, four queued, 0xA6 dropped
      push_seq('{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6});
      chk("ovf_flag",  32'(bus.overflow),   32'd1);
      chk("ovf_full",  32'(bus.fifo_full),  32'd1);
      chk("ovf_count", 32'(bus.fifo_count), 32'd4);
      frame(8'hA1, 4, 1'b0, 8'h00);
      frame(8'hA2, 0, 1'b0, 8'h00);
      frame(8'hA3, 0, 1'b0, 8'h00);
      frame(8'hA4, 0, 1'b0, 8'h00);
      frame(8'hA5, 0, 1'b0, 8'h00);
      idle_chk("ovf_end");
      chk("ovf_sticky", 32'(bus.overflow), 32'd1);

      // Reset during DATA with two bytes queued
      push_seq('{8'hB1, 8'hB2, 8'hB3});
      chk("abort_count", 32'(bus.fifo_count), 32'd2);
      repeat (8) @(negedge clk);
      chk("abort_data_bit", 32'(bus.tx), 32'(line_bit(8'hB1, 2)));
      rst = 1'b1;
      #1;
      idle_chk("abort_rst");
      chk("abort_full", 32'(bus.fifo_full), 32'd0);
      chk("abort_ovf",  32'(bus.overflow),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         chk($sformatf("post_abort_tx_%0d", i),   32'(bus.tx), 32'd1);
         chk($sformatf("post_abort_busy_%0d", i), 32'(bus.is_transmitting), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, giving clk cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have parameter DEPTH, default 8, giving the FIFO entry count; must be a power of two, 2..64.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 transmit  input  1  write strobe; each cycle it is high requests a push of tx_byte.
REQ-006 tx_byte  input  8  byte to enqueue.
REQ-007 tx  output  1  serial line, 8N1, LSB first, idle high.
REQ-008 is_transmitting  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-009 fifo_full  output  1  high when the FIFO holds DEPTH entries.
REQ-010 fifo_count  output  log2(DEPTH)+1  number of queued bytes, excluding the byte currently being shifted.
REQ-011 overflow  output  1  sticky flag, set by a dropped push.

Function
REQ-012 Push: when transmit=1 at an edge, tx_byte SHALL be written to the FIFO tail, unless the FIFO is full and no pop occurs on that edge.
REQ-013 A push while full with a simultaneous pop SHALL be accepted, leaving fifo_count unchanged.
REQ-014 A rejected push SHALL discard the byte, set overflow=1 and leave FIFO contents unchanged.
REQ-015 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-016 IDLE -> START: when the FIFO is non-empty at an edge, the head SHALL be popped into the shift register on that edge, and tx SHALL be 0 from that edge.
REQ-017 Latency: a push at edge N into an empty FIFO with the FSM in IDLE SHALL make tx fall at edge N+1.
REQ-018 START: tx=0 for exactly CLKS_PER_BIT cycles, then -> DATA.
REQ-019 DATA: bits 0..7 SHALL be driven LSB first, each for exactly CLKS_PER_BIT cycles, counted by a 3-bit bit index; after bit 7 the FSM SHALL go -> STOP.
REQ-020 STOP: tx=1 for exactly CLKS_PER_BIT cycles.
REQ-021 At the end of STOP, if the FIFO is non-empty, the FSM SHALL pop and go directly to START with no idle cycle; otherwise -> IDLE.
REQ-022 Each frame SHALL last exactly 10*CLKS_PER_BIT cycles.
REQ-023 The baud counter SHALL count 0..CLKS_PER_BIT-1, wrap to 0 at each bit boundary, and reset to 0 on every state entry.
REQ-024 FIFO read and write pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by fifo_count, never by pointer equality alone.
REQ-025 tx SHALL be driven directly from a register, with no combinational path from any input.
REQ-026 is_transmitting SHALL equal (state != IDLE) || (fifo_count != 0), derived from registers.
REQ-027 A push on the same edge as an IDLE->START pop from an empty FIFO is impossible; a push during IDLE with a non-empty FIFO SHALL be queued behind the head.

Reset
REQ-028 While rst=1, the block SHALL hold: state=IDLE, tx=1, is_transmitting=0, fifo_full=0, fifo_count=0, overflow=0, and pointers, baud counter and bit index at 0.
REQ-029 rst asserted mid-frame SHALL immediately abort the frame and force tx=1, and SHALL flush all queued bytes.
REQ-030 overflow SHALL be cleared only by rst.
REQ-031 FIFO storage contents need not be reset.

Verification (CLKS_PER_BIT=4, DEPTH=4)
REQ-032 Single byte: push 0xA5 at edge N -> tx falls at N+1; line sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; is_transmitting falls at N+41.
REQ-033 Back-to-back: push 0x00 then 0xFF on consecutive edges -> two frames of 40 cycles each with no gap; tx high after the 80th cycle.
REQ-034 Overflow: 6 pushes on consecutive cycles starting from IDLE -> 1 byte is shifting, 4 are queued, 1 is dropped; overflow=1 and fifo_full=1; 5 frames are transmitted in order.
REQ-035 Push while full with a simultaneous pop at the STOP->START boundary -> byte accepted, overflow stays 0, fifo_count stays 4.
REQ-036 Reset in the middle of the DATA state with 2 bytes queued -> tx=1 and fifo_count=0 in the same cycle; no further frames are transmitted after rst is released.
REQ-037 Idle check: no pushes for 100 cycles after reset -> tx stays 1 and is_transmitting stays 0.
